// File: rtl/systolic.sv
// Output-stationary SIZE x SIZE systolic multiply-accumulate array.
// Row operands shift east, column operands shift south; each PE keeps its own running sum.

module systolic_pe #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IN_WIDTH-1:0]  a_west,
   input  logic                 va_west,
   input  logic [IN_WIDTH-1:0]  b_north,
   input  logic                 vb_north,
   output logic [IN_WIDTH-1:0]  a_r,
   output logic                 va_r,
   output logic [IN_WIDTH-1:0]  b_r,
   output logic                 vb_r,
   output logic [OUT_WIDTH-1:0] acc
);

   localparam int PROD_W = 2 * IN_WIDTH;

   logic [PROD_W-1:0] prod;
   logic              pv;

   // Operands move on every edge whether or not they are valid; only pv gates the sum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_r  <= '0;
         va_r <= 1'b0;
         b_r  <= '0;
         vb_r <= 1'b0;
         prod <= '0;
         pv   <= 1'b0;
         acc  <= '0;
      end else begin
         a_r  <= a_west;
         va_r <= va_west;
         b_r  <= b_north;
         vb_r <= vb_north;
         prod <= PROD_W'(a_r) * PROD_W'(b_r);
         pv   <= va_r & vb_r;
         if (pv)
            acc <= acc + OUT_WIDTH'(prod);
      end
   end

endmodule

module systolic #(
   parameter int SIZE      = 2,
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IN_WIDTH-1:0]  a_in [SIZE],
   input  logic [SIZE-1:0]      valid_a,
   input  logic [IN_WIDTH-1:0]  b_in [SIZE],
   input  logic [SIZE-1:0]      valid_b,
   output logic [OUT_WIDTH-1:0] out [SIZE][SIZE]
);

   // a_net[i][j] is the west source of PE(i,j); column SIZE is the east edge of the array.
   logic [IN_WIDTH-1:0] a_net  [SIZE][SIZE+1];
   logic                va_net [SIZE][SIZE+1];
   // b_net[i][j] is the north source of PE(i,j); row SIZE is the south edge.
   logic [IN_WIDTH-1:0] b_net  [SIZE+1][SIZE];
   logic                vb_net [SIZE+1][SIZE];

   for (genvar k = 0; k < SIZE; k++) begin : g_edge
      assign a_net[k][0]  = a_in[k];
      assign va_net[k][0] = valid_a[k];
      assign b_net[0][k]  = b_in[k];
      assign vb_net[0][k] = valid_b[k];
   end

   for (genvar i = 0; i < SIZE; i++) begin : g_row
      for (genvar j = 0; j < SIZE; j++) begin : g_col
         systolic_pe #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
         ) u_pe (
            .clk      (clk),
            .reset    (reset),
            .a_west   (a_net[i][j]),
            .va_west  (va_net[i][j]),
            .b_north  (b_net[i][j]),
            .vb_north (vb_net[i][j]),
            .a_r      (a_net[i][j+1]),
            .va_r     (va_net[i][j+1]),
            .b_r      (b_net[i+1][j]),
            .vb_r     (vb_net[i+1][j]),
            .acc      (out[i][j])
         );
      end
   end

endmodule

// File: tb/tb_systolic.sv
// Bench for systolic: directed table, skewed 2x2 product, wrap, async reset, then random
// traffic compared against a history-based matrix-product model.

module tb_systolic;

   localparam int S = 2;

   logic        clk;
   logic        reset;
   logic [7:0]  a_in [S];
   logic [S-1:0] valid_a;
   logic [7:0]  b_in [S];
   logic [S-1:0] valid_b;
   logic [31:0] out32 [S][S];
   logic [15:0] out16 [S][S];

   int errors = 0;
   int checks = 0;

   systolic #(.SIZE(S), .IN_WIDTH(8), .OUT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .a_in(a_in), .valid_a(valid_a),
      .b_in(b_in), .valid_b(valid_b), .out(out32)
   );

   systolic #(.SIZE(S), .IN_WIDTH(8), .OUT_WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .a_in(a_in), .valid_a(valid_a),
      .b_in(b_in), .valid_b(valid_b), .out(out16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: every sample presented at an edge since the last reset release.
   typedef struct packed {
      logic [S-1:0][7:0] a;
      logic [S-1:0]      va;
      logic [S-1:0][7:0] b;
      logic [S-1:0]      vb;
   } samp_t;
   samp_t hist[$];

   typedef struct {
      logic [7:0]  a0, a1;
      logic [1:0]  va;
      logic [7:0]  b0, b1;
      logic [1:0]  vb;
      logic [31:0] e00, e01, e10, e11;
   } vec_t;
   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Sample k on row i meets sample k' on column j in PE(i,j) at edge k+j == k'+i,
   // and the product shows on the output two edges later.
   function automatic logic [63:0] model(input int i, input int j);
      logic [63:0] s;
      int n;
      s = '0;
      n = hist.size();
      for (int e = 0; e <= n - 3; e++) begin
         int ka, kb;
         ka = e - j;
         kb = e - i;
         if (ka >= 0 && kb >= 0 && hist[ka].va[i] && hist[kb].vb[j])
            s += 64'(hist[ka].a[i]) * 64'(hist[kb].b[j]);
      end
      return s;
   endfunction

   task automatic check_model();
      logic [63:0] m;
      for (int i = 0; i < S; i++)
         for (int j = 0; j < S; j++) begin
            m = model(i, j);
            check($sformatf("model32[%0d][%0d]", i, j), out32[i][j], m[31:0]);
            check($sformatf("model16[%0d][%0d]", i, j), {16'b0, out16[i][j]}, {16'b0, m[15:0]});
         end
   endtask

   task automatic check_zero(input string name);
      for (int i = 0; i < S; i++)
         for (int j = 0; j < S; j++) begin
            check($sformatf("%s32[%0d][%0d]", name, i, j), out32[i][j], 32'd0);
            check($sformatf("%s16[%0d][%0d]", name, i, j), {16'b0, out16[i][j]}, 32'd0);
         end
   endtask

   task automatic drive(input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] va,
                        input logic [7:0] b0, input logic [7:0] b1, input logic [1:0] vb);
      a_in[0] = a0;
      a_in[1] = a1;
      valid_a = va;
      b_in[0] = b0;
      b_in[1] = b1;
      valid_b = vb;
   endtask

   task automatic step();
      samp_t s;
      @(posedge clk);
      if (reset) begin
         for (int k = 0; k < S; k++) begin
            s.a[k] = a_in[k];
            s.b[k] = b_in[k];
         end
         s.va = valid_a;
         s.vb = valid_b;
         hist.push_back(s);
      end
      #1;
      check_model();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      hist.delete();
      drive(0, 0, 2'b00, 0, 0, 2'b00);
      step();
      reset = 1'b1;
   endtask

   initial begin
      tbl[0] = '{1, 0, 2'b01, 1, 0, 2'b01, 0, 0, 0, 0};
      tbl[1] = '{2, 0, 2'b01, 4, 2, 2'b11, 0, 0, 0, 0};
      tbl[2] = '{0, 0, 2'b00, 0, 5, 2'b10, 1, 0, 0, 0};
      tbl[3] = '{0, 0, 2'b00, 0, 0, 2'b00, 9, 2, 0, 0};
      tbl[4] = '{0, 0, 2'b00, 0, 0, 2'b00, 9, 12, 0, 0};
      tbl[5] = '{0, 0, 2'b00, 0, 0, 2'b00, 9, 12, 0, 0};
      tbl[6] = '{9, 0, 2'b01, 9, 0, 2'b00, 9, 12, 0, 0};
      tbl[7] = '{9, 0, 2'b00, 9, 0, 2'b01, 9, 12, 0, 0};
      tbl[8] = '{0, 0, 2'b00, 0, 0, 2'b00, 9, 12, 0, 0};
      tbl[9] = '{0, 0, 2'b00, 0, 0, 2'b00, 9, 12, 0, 0};

      // Reset held with live valid data on the inputs.
      reset = 1'b0;
      drive(5, 5, 2'b11, 7, 7, 2'b11);
      step();
      step();
      check_zero("reset_hold");
      reset = 1'b1;
      drive(0, 0, 2'b00, 0, 0, 2'b00);
      step();
      check_zero("post_release");

      // PE(0,0) latency, row propagation into PE(0,1), valid gating.
      for (int k = 0; k < 10; k++) begin
         drive(tbl[k].a0, tbl[k].a1, tbl[k].va, tbl[k].b0, tbl[k].b1, tbl[k].vb);
         step();
         check($sformatf("tbl%0d_00", k), out32[0][0], tbl[k].e00);
         check($sformatf("tbl%0d_01", k), out32[0][1], tbl[k].e01);
         check($sformatf("tbl%0d_10", k), out32[1][0], tbl[k].e10);
         check($sformatf("tbl%0d_11", k), out32[1][1], tbl[k].e11);
      end

      // Full 2x2 with feeder skew: A=[[1,2],[3,4]], B=[[5,6],[7,8]].
      do_reset();
      drive(1, 0, 2'b01, 5, 0, 2'b01); step();
      drive(2, 3, 2'b11, 7, 6, 2'b11); step();
      drive(0, 4, 2'b10, 0, 8, 2'b10); step();
      drive(0, 0, 2'b00, 0, 0, 2'b00);
      repeat (4) step();
      check("mm_00", out32[0][0], 32'd19);
      check("mm_01", out32[0][1], 32'd22);
      check("mm_10", out32[1][0], 32'd43);
      check("mm_11", out32[1][1], 32'd50);

      // 255*255 twice: wraps in the 16-bit array only.
      do_reset();
      drive(255, 0, 2'b01, 255, 0, 2'b01);
      step();
      step();
      drive(0, 0, 2'b00, 0, 0, 2'b00);
      repeat (3) step();
      check("wrap16", {16'b0, out16[0][0]}, 32'd64514);
      check("nowrap32", out32[0][0], 32'd130050);

      // Asynchronous reset between edges with data in flight.
      drive(255, 255, 2'b11, 255, 255, 2'b11);
      step();
      step();
      #3;
      reset = 1'b0;
      hist.delete();
      #1;
      check_zero("async");
      step();
      reset = 1'b1;

      // Random traffic with occasional mid-cycle reset pulses.
      repeat (300) begin
         drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
         step();
         if ($urandom_range(0, 49) == 0) begin
            #2;
            reset = 1'b0;
            hist.delete();
            #1;
            check_zero("rand_async");
            @(posedge clk);
            #1;
            reset = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/systolic.md
Name: systolic

Overview:
- SIZE x SIZE output-stationary systolic matrix-multiply array of multiply-accumulate processing elements (PEs).
- Row operands enter on the left edge and shift right; column operands enter on the top edge and shift down.
- Each PE(i,j) accumulates the products of the operand pairs that meet in it. Its running sum drives out[i][j].
- Used as the compute core of the matrix-multiply datapath. The feeder supplies the operand skew.

Parameters:
SIZE, 2, array dimension (rows = columns = SIZE); SIZE >= 1
IN_WIDTH, 8, operand width, unsigned
OUT_WIDTH, 32, accumulator/output width, unsigned

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
a_in  input  IN_WIDTH x [SIZE]  a_in[i] = operand entering row i at PE(i,0)
valid_a  input  1 x [SIZE]  valid_a[i] qualifies a_in[i]
b_in  input  IN_WIDTH x [SIZE]  b_in[j] = operand entering column j at PE(0,j)
valid_b  input  1 x [SIZE]  valid_b[j] qualifies b_in[j]
out  output  OUT_WIDTH x [SIZE][SIZE]  out[i][j] = accumulator of PE(i,j)

Behaviour:
- Reset (reset==0, asynchronous): all operand, valid, product and accumulator registers clear to 0, so every out[i][j] = 0. Outputs hold 0 for as long as reset stays low. Asserting reset mid-stream discards all in-flight data. Accumulation restarts from 0 after release.
- Each PE has three register stages per clock edge.
  - Operand stage: a_r/va_r load from the west source and b_r/vb_r load from the north source. Data loads regardless of valid.
    - West source: a_in[i]/valid_a[i] for column 0, otherwise PE(i,j-1).a_r/va_r.
    - North source: b_in[j]/valid_b[j] for row 0, otherwise PE(i-1,j).b_r/vb_r.
  - Product stage: prod <= a_r * b_r, full 2*IN_WIDTH unsigned; pv <= va_r & vb_r.
  - Accumulate stage: if pv, acc <= acc + zero-extended prod, modulo 2^OUT_WIDTH (wraps silently). Otherwise acc holds.
- out[i][j] = acc of PE(i,j), a direct register output with no extra delay.
- Propagation:
  - A sample presented at edge t reaches PE(i,j).a_r at edge t+j.
  - A sample presented at edge t reaches PE(i,j).b_r at edge t+i.
- Latency: a pair that meets in PE(i,j)'s operand stage at edge e is visible on out[i][j] after edge e+2.
- A pair with either valid low contributes nothing. This holds even when the data is nonzero.
- There is no clear or start input. Accumulators only ever grow (modulo wrap) until reset.
- Feeder contract: row i stream is delayed i cycles and column j stream is delayed j cycles. With that skew, C = A x B, where A[i][k] is the k-th sample on row i and B[k][j] is the k-th sample on column j. Every out[i][j] is final 3*SIZE-1 edges after the first sample.
- No backpressure and no handshake: inputs are sampled every edge.
- Structure: a PE submodule plus a generate array. Inter-PE valid/data nets are explicit.

Test Plan:
- Reset: hold reset=0 with a_in=5, b_in=7 and all valids=1, for 2 edges -> all out=0. Release reset with all valids=0 -> out stays 0.
- PE(0,0) latency: release reset; then feed the following on successive edges, with everything else invalid -> out[0][0]=0 through edge 2, =1 after edge 3, =9 after edge 4, and holds 9.
  - edge 1: a_in[0]=1, b_in[0]=1
  - edge 2: a_in[0]=2, b_in[0]=4
- Row propagation / 2x2 skew, [1 2] x [[1 2],[4 5]]: continue from the previous scenario and feed b_in[1]=2 at edge 2 and 5 at edge 3 (valid_b[1] high only then) -> out[0][1]=2 after edge 4 and 12 after edge 5. Row 1 stays 0.
- Full 2x2: A=[[1,2],[3,4]], B=[[5,6],[7,8]], fed with the row/column skew -> out = [[19,22],[43,50]] by edge 5 after the first sample, then stable.
- Valid gating: a_in[0]=9 valid, b_in[0]=9 with valid_b[0]=0 -> out[0][0] unchanged.
- Wrap and async reset: OUT_WIDTH=16, accumulate 255*255 twice -> 130050 mod 65536 = 64514. Drop reset asynchronously mid-stream, between edges -> out=0 immediately.
